// File: rtl/bt_cmd_decoder.sv
// Bluetooth command decoder: turns validated UART bytes '0'..'6' into a registered
// one-hot motion command and manual/auto mode, with a manual-mode link watchdog.
module bt_cmd_decoder #(
  parameter int CLK_HZ     = 125_000_000,
  parameter int TIMEOUT_MS = 500
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       rx_frame_err,
  output logic [4:0] motion,
  output logic       auto_mode,
  output logic       cmd_strobe,
  output logic       timeout,
  output logic [7:0] reject_cnt
);

  localparam int TIMEOUT_CYC = (CLK_HZ / 1000) * TIMEOUT_MS;
  localparam int TW          = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT_CYC - 1);

  localparam logic [4:0] MOT_FWD  = 5'b00001;
  localparam logic [4:0] MOT_STOP = 5'b10000;

  localparam logic [7:0] CH_STOP   = 8'h34;
  localparam logic [7:0] CH_MANUAL = 8'h35;
  localparam logic [7:0] CH_AUTO   = 8'h36;
  localparam logic [7:0] CH_CR     = 8'h0D;
  localparam logic [7:0] CH_LF     = 8'h0A;

  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_AUTO   = 1'b1
  } mode_e;

  mode_e         mode_q,    mode_d;
  logic [4:0]    motion_q,  motion_d;
  logic          strobe_q,  strobe_d;
  logic          timeout_q, timeout_d;
  logic [7:0]    rej_q,     rej_d;
  logic [TW-1:0] wd_q,      wd_d;

  logic byte_ok;
  logic is_move;
  logic is_stop;
  logic is_manual;
  logic is_auto;
  logic is_eol;
  logic is_known;
  logic accept;
  logic reject;
  logic moving;
  logic wd_expire;

  // A frame error poisons the byte even if rx_valid is also high.
  assign byte_ok   = rx_valid & ~rx_frame_err;
  assign is_move   = (rx_data[7:2] == 6'b001100);
  assign is_stop   = (rx_data == CH_STOP);
  assign is_manual = (rx_data == CH_MANUAL);
  assign is_auto   = (rx_data == CH_AUTO);
  assign is_eol    = (rx_data == CH_CR) | (rx_data == CH_LF);
  assign is_known  = is_move | is_stop | is_manual | is_auto | is_eol;

  assign accept = byte_ok &
                  ((is_move & (mode_q == MODE_MANUAL)) | is_stop | is_manual | is_auto);
  assign reject = rx_frame_err |
                  (byte_ok & ((is_move & (mode_q == MODE_AUTO)) | ~is_known));

  assign moving    = (mode_q == MODE_MANUAL) && (motion_q != MOT_STOP);
  // An accepted command on the expiry cycle takes precedence over the watchdog.
  assign wd_expire = moving && (wd_q == WD_LAST) && !accept;

  always_ff @(posedge clk) begin
    if (reset_p) begin
      mode_q    <= MODE_MANUAL;
      motion_q  <= MOT_STOP;
      strobe_q  <= 1'b0;
      timeout_q <= 1'b0;
      rej_q     <= 8'd0;
      wd_q      <= '0;
    end else begin
      mode_q    <= mode_d;
      motion_q  <= motion_d;
      strobe_q  <= strobe_d;
      timeout_q <= timeout_d;
      rej_q     <= rej_d;
      wd_q      <= wd_d;
    end
  end

  always_comb begin
    mode_d    = mode_q;
    motion_d  = motion_q;
    strobe_d  = accept;
    timeout_d = 1'b0;
    rej_d     = rej_q;
    wd_d      = '0;

    if (reject && (rej_q != 8'hFF)) begin
      rej_d = rej_q + 8'd1;
    end

    if (accept) begin
      if (is_move) begin
        motion_d = MOT_FWD << rx_data[1:0];
      end else if (is_stop) begin
        motion_d = MOT_STOP;
      end else if (is_manual) begin
        mode_d = MODE_MANUAL;
      end else begin
        mode_d   = MODE_AUTO;
        motion_d = MOT_STOP;
      end
    end else if (wd_expire) begin
      motion_d  = MOT_STOP;
      timeout_d = 1'b1;
    end else if (moving) begin
      wd_d = wd_q + TW'(1);
    end
  end

  assign motion     = motion_q;
  assign auto_mode  = (mode_q == MODE_AUTO);
  assign cmd_strobe = strobe_q;
  assign timeout    = timeout_q;
  assign reject_cnt = rej_q;

endmodule

// File: tb/tb_bt_cmd_decoder.sv
// Bench for bt_cmd_decoder: directed test-plan checks with literal expectations plus
// randomized traffic compared every cycle against a deadline-based behavioural model.
module tb_bt_cmd_decoder;

  localparam int CLK_HZ     = 1000;
  localparam int TIMEOUT_MS = 10;
  localparam int TCYC       = (CLK_HZ / 1000) * TIMEOUT_MS;

  logic       clk = 1'b0;
  logic       reset_p = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_frame_err = 1'b0;
  logic [4:0] motion;
  logic       auto_mode;
  logic       cmd_strobe;
  logic       timeout;
  logic [7:0] reject_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  bt_cmd_decoder #(.CLK_HZ(CLK_HZ), .TIMEOUT_MS(TIMEOUT_MS)) dut (
    .clk          (clk),
    .reset_p      (reset_p),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err),
    .motion       (motion),
    .auto_mode    (auto_mode),
    .cmd_strobe   (cmd_strobe),
    .timeout      (timeout),
    .reject_cnt   (reject_cnt)
  );

  always #5 clk = ~clk;

  // Model: direction index (0..3 moving, 4 stop), mode, and an absolute watchdog
  // deadline set to (edge of last accepted command + TCYC).
  bit          model_ok = 1'b0;
  int unsigned edge_n = 0;
  int unsigned m_deadline = 0;
  int          m_dir = 4;
  bit          m_auto = 1'b0;
  bit          m_str = 1'b0;
  bit          m_to = 1'b0;
  int          m_cnt = 0;

  always @(posedge clk) begin
    int  nd;
    bit  na;
    bit  acc;
    bit  rej;
    bit  to;
    edge_n <= edge_n + 1;
    if (reset_p) begin
      m_dir    <= 4;
      m_auto   <= 1'b0;
      m_str    <= 1'b0;
      m_to     <= 1'b0;
      m_cnt    <= 0;
      model_ok <= 1'b1;
    end else begin
      nd  = m_dir;
      na  = m_auto;
      acc = 1'b0;
      rej = 1'b0;
      to  = 1'b0;
      if (rx_frame_err) begin
        rej = 1'b1;
      end else if (rx_valid) begin
        if (rx_data >= 8'h30 && rx_data <= 8'h33) begin
          if (m_auto) rej = 1'b1;
          else begin
            acc = 1'b1;
            nd  = int'(rx_data) - 'h30;
          end
        end else if (rx_data == 8'h34) begin
          acc = 1'b1; nd = 4;
        end else if (rx_data == 8'h35) begin
          acc = 1'b1; na = 1'b0;
        end else if (rx_data == 8'h36) begin
          acc = 1'b1; na = 1'b1; nd = 4;
        end else if (rx_data != 8'h0D && rx_data != 8'h0A) begin
          rej = 1'b1;
        end
      end
      if (!acc && !m_auto && m_dir != 4 && edge_n == m_deadline) begin
        to = 1'b1;
        nd = 4;
      end
      if (acc) m_deadline <= edge_n + TCYC;
      m_dir  <= nd;
      m_auto <= na;
      m_str  <= acc;
      m_to   <= to;
      m_cnt  <= (rej && m_cnt < 255) ? m_cnt + 1 : m_cnt;
    end
  end

  always @(negedge clk) begin
    logic [4:0] exp_mot;
    if (model_ok) begin
      exp_mot = 5'(1 << m_dir);
      n_cmp++;
      if (motion !== exp_mot || auto_mode !== m_auto || cmd_strobe !== m_str ||
          timeout !== m_to || reject_cnt !== 8'(m_cnt)) begin
        n_bad++;
        if (n_bad <= 20)
          $display("FAIL model_cycle t=%0t: got mot=%b auto=%b str=%b to=%b cnt=%0d, expected mot=%b auto=%b str=%b to=%b cnt=%0d",
                   $time, motion, auto_mode, cmd_strobe, timeout, reject_cnt,
                   exp_mot, m_auto, m_str, m_to, m_cnt);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s = 0x%0h", name, act);
    end
  endtask

  // Called on a negedge; returns on the next negedge with the byte's effect visible.
  task automatic send(input logic [7:0] d, input logic v, input logic fe);
    rx_data      = d;
    rx_valid     = v;
    rx_frame_err = fe;
    @(negedge clk);
    rx_valid     = 1'b0;
    rx_frame_err = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    int found;
    int seen;
    int base;
    int dens;
    @(negedge clk);
    reset_p = 1'b1;
    idle(3);
    reset_p = 1'b0;
    idle(20);
    chk("reset_motion", motion, 5'b10000);
    chk("reset_auto", auto_mode, 0);
    chk("reset_strobe", cmd_strobe, 0);
    chk("reset_timeout", timeout, 0);
    chk("reset_cnt", reject_cnt, 0);

    send(8'h30, 1, 0);
    chk("fwd_motion", motion, 5'b00001);
    chk("fwd_strobe", cmd_strobe, 1);
    idle(1);
    chk("strobe_one_cycle", cmd_strobe, 0);
    send(8'h33, 1, 0);
    chk("right_motion", motion, 5'b01000);

    send(8'h31, 1, 0);
    chk("bwd_motion", motion, 5'b00010);
    found = -1;
    for (int k = 1; k <= 3 * TCYC && found < 0; k++) begin
      idle(1);
      if (timeout) found = k;
    end
    chk("wd_expire_cycle", found, 10);
    chk("wd_stop", motion, 5'b10000);
    idle(1);
    chk("wd_pulse_one_cycle", timeout, 0);

    send(8'h31, 1, 0);
    idle(8);
    send(8'h31, 1, 0);
    chk("wd_resend_strobe", cmd_strobe, 1);
    seen = 0;
    for (int k = 0; k < 9; k++) begin
      idle(1);
      if (timeout || motion != 5'b00010) seen++;
    end
    chk("wd_restart_quiet", seen, 0);
    idle(1);
    chk("wd_restart_fire", timeout, 1);

    send(8'h30, 1, 0);
    send(8'h36, 1, 0);
    chk("auto_flag", auto_mode, 1);
    chk("auto_stop", motion, 5'b10000);
    send(8'h30, 1, 0);
    chk("auto_move_ignored", motion, 5'b10000);
    chk("auto_move_rej", reject_cnt, 1);
    chk("auto_move_nostrobe", cmd_strobe, 0);
    send(8'h34, 1, 0);
    chk("auto_stop_strobe", cmd_strobe, 1);
    send(8'h35, 1, 0);
    chk("manual_flag", auto_mode, 0);
    chk("manual_strobe", cmd_strobe, 1);

    send(8'h32, 1, 0);
    base = reject_cnt;
    seen = 0;
    send(8'h41, 1, 0); seen += cmd_strobe;
    send(8'h0D, 1, 0); seen += cmd_strobe;
    send(8'h0A, 1, 0); seen += cmd_strobe;
    send(8'h30, 1, 1); seen += cmd_strobe;
    chk("rej_delta", reject_cnt - base, 2);
    chk("rej_motion_kept", motion, 5'b00100);
    chk("rej_no_strobe", seen, 0);
    send(8'h00, 0, 1);
    chk("ferr_no_valid", reject_cnt - base, 3);

    for (int k = 0; k < 300; k++) send(8'h7A, 1, 0);
    chk("rej_saturate", reject_cnt, 255);

    reset_p = 1'b1;
    idle(1);
    reset_p = 1'b0;
    for (int seg = 0; seg < 60; seg++) begin
      dens = (seg % 3 == 0) ? 2 : ((seg % 3 == 1) ? 8 : 30);
      for (int k = 0; k < 40; k++) begin
        int r;
        reset_p      = ($urandom_range(0, 499) == 0);
        rx_valid     = ($urandom_range(0, dens - 1) == 0);
        rx_frame_err = ($urandom_range(0, 15) == 0);
        r = $urandom_range(0, 9);
        if (r <= 6)      rx_data = 8'(8'h30 + r);
        else if (r == 7) rx_data = $urandom_range(0, 1) ? 8'h0D : 8'h0A;
        else if (r == 8) rx_data = 8'($urandom);
        else             rx_data = 8'(8'h30 + $urandom_range(0, 3));
        @(negedge clk);
      end
    end
    reset_p = 1'b0;
    rx_valid = 1'b0;
    rx_frame_err = 1'b0;
    idle(2);

    send(8'h30, 1, 0);
    reset_p = 1'b1;
    send(8'h30, 1, 0);
    reset_p = 1'b0;
    chk("rst_over_valid_motion", motion, 5'b10000);
    chk("rst_over_valid_strobe", cmd_strobe, 0);
    chk("rst_over_valid_auto", auto_mode, 0);
    chk("rst_over_valid_cnt", reject_cnt, 0);
    chk("rst_over_valid_to", timeout, 0);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bt_cmd_decoder.md
Name: bt_cmd_decoder

Overview:
- Downstream stage of the Bluetooth UART receiver.
- Consumes received bytes with a valid strobe and decodes the ASCII command set '0'..'6' into a registered one-hot drive command plus a manual/auto mode flag.
- Adds a watchdog: in manual mode, motion reverts to STOP if the link goes silent.
- Feeds the car motor/mode controller in place of ad-hoc byte compares.

Parameters:
- CLK_HZ, 125_000_000, system clock frequency in Hz.
- TIMEOUT_MS, 500, manual-mode command watchdog period in ms.
- Derived (localparam, not overridable):
  - TIMEOUT_CYC = (CLK_HZ/1000)*TIMEOUT_MS.
  - TW = $clog2(TIMEOUT_CYC+1).

Ports:
- clk  in  1  system clock; the only clock.
- reset_p  in  1  synchronous, active-high reset.
- rx_data  in  8  received byte; sampled only when rx_valid=1.
- rx_valid  in  1  one-cycle strobe, byte available.
- rx_frame_err  in  1  one-cycle strobe, the byte on this cycle had a bad stop bit.
- motion  out  5  one-hot level: [0] FWD, [1] BWD, [2] LEFT, [3] RIGHT, [4] STOP.
- auto_mode  out  1  0 = MANUAL, 1 = AUTO.
- cmd_strobe  out  1  one-cycle pulse when a command is accepted.
- timeout  out  1  one-cycle pulse when the watchdog forces STOP.
- reject_cnt  out  8  saturating count of rejected bytes.

Behaviour:
- All outputs are registered.
- Reset values (reset_p sampled high on a clk edge):
  - motion = 5'b10000 (STOP), auto_mode = 0, cmd_strobe = 0, timeout = 0, reject_cnt = 0.
  - Watchdog counter = 0.
- Reset asserted mid-operation overrides everything, including an rx_valid on the same cycle.
- Latency: rx_valid in cycle N -> motion, auto_mode and cmd_strobe reflect it in cycle N+1. No backpressure; one byte per cycle is accepted.
- Byte classification (only when rx_valid=1 and rx_frame_err=0):
  - 0x30..0x33 ('0'..'3'), motion commands FWD/BWD/LEFT/RIGHT:
    - MANUAL: motion is set to the matching one-hot, cmd_strobe pulses.
    - AUTO: the byte is ignored and reject_cnt increments.
  - 0x34 ('4') STOP: accepted in both modes; motion = STOP, cmd_strobe pulses.
  - 0x35 ('5') MANUAL: auto_mode = 0; motion unchanged; cmd_strobe pulses, including when already MANUAL.
  - 0x36 ('6') AUTO: auto_mode = 1; motion forced to STOP; cmd_strobe pulses.
  - 0x0D and 0x0A (CR/LF): silently ignored; no strobe, no count.
  - Any other value: ignored; reject_cnt increments.
- rx_frame_err = 1: the byte is dropped and reject_cnt increments. This applies whether or not rx_valid is high on the same cycle.
- reject_cnt saturates at 255; it clears only on reset.
- Watchdog (MANUAL only):
  - The counter reloads to 0 on every accepted command.
  - Otherwise it increments each cycle while auto_mode = 0 and motion != STOP.
  - When it reaches TIMEOUT_CYC-1: next cycle motion = STOP, timeout pulses for one cycle, counter = 0.
  - The counter is held at 0 while motion = STOP or auto_mode = 1.
  - Expiry and an accepted command on the same cycle: the command wins; no timeout pulse, counter reloads.
- motion is always exactly one-hot; no encoding other than the five listed is ever output.

Test Plan:
- Reset, then idle 20 cycles -> motion=5'b10000, auto_mode=0, cmd_strobe=0, reject_cnt=0.
- rx_valid with 0x30 -> next cycle motion=5'b00001 and cmd_strobe=1 for one cycle. Then 0x33 -> motion=5'b01000.
- CLK_HZ=1000, TIMEOUT_MS=10 (TIMEOUT_CYC=10):
  - Send 0x31 and wait -> motion returns to 5'b10000 and timeout pulses exactly 10 cycles after cmd_strobe.
  - Resend 0x31 at cycle 9 -> no timeout; the period restarts.
- Send 0x36 while motion=FWD -> auto_mode=1, motion=STOP. Then 0x30 -> motion stays STOP, reject_cnt +1. Then 0x34 -> cmd_strobe=1. Then 0x35 -> auto_mode=0.
- Send 0x41, 0x0D, 0x0A, then rx_valid+rx_frame_err with 0x30 -> reject_cnt=2, motion unchanged, no cmd_strobe.
- Send 300 bytes of 0x7A -> reject_cnt=255 (saturated). Assert reset_p on the same cycle as rx_valid 0x30 -> all outputs at reset values.
